// File: rtl/div32.sv
// 32-bit iterative restoring divider, signed or unsigned, one quotient bit per clock.
// Note: denom carries the dividend and num carries the divisor.
module div32 (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] denom,
  input  logic [31:0] num,
  input  logic        signed_div,
  input  logic        valid,
  output logic        ready,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic [1:0]  dbg_state_o
);

  // Handshake: the requester raises valid and holds it until ready is seen,
  // then drops it. ready stays high, with q/r stable, until valid=0 is sampled.
  // A new request is accepted only in IDLE.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [31:0] dvnd_q, dvnd_d;
  logic        neg_q_q, neg_q_d;
  logic        neg_r_q, neg_r_d;
  logic        div0_q, div0_d;
  logic        ready_q, ready_d;
  logic [31:0] q_q, q_d;
  logic [31:0] r_q, r_d;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] shifted;
  logic [33:0] diff;

  assign a_neg = signed_div & denom[31];
  assign b_neg = signed_div & num[31];
  assign a_mag = a_neg ? (~denom + 32'd1) : denom;
  assign b_mag = b_neg ? (~num + 32'd1) : num;

  // The 33-bit shifted partial remainder keeps a 0x80000000 magnitude exact.
  assign shifted = {rem_q, quo_q[31]};
  assign diff    = {1'b0, shifted} - {2'b00, dvsr_q};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (valid) state_d = S_CALC;
      S_CALC: if (cnt_q == 5'd31) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: if (!valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic
  always_comb begin
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    dvnd_d  = dvnd_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    div0_d  = div0_q;
    ready_d = ready_q;
    q_d     = q_q;
    r_d     = r_q;
    case (state_q)
      S_IDLE: begin
        if (valid) begin
          cnt_d   = 5'd0;
          quo_d   = a_mag;
          rem_d   = 32'd0;
          dvsr_d  = b_mag;
          dvnd_d  = denom;
          neg_q_d = a_neg ^ b_neg;
          neg_r_d = a_neg;
          div0_d  = (num == 32'd0);
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (!diff[33]) begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shifted[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
      end
      S_FIX: begin
        ready_d = 1'b1;
        // Divide-by-zero bypasses sign correction so q is all ones in both modes.
        if (div0_q) begin
          q_d = 32'hFFFF_FFFF;
          r_d = dvnd_q;
        end else begin
          q_d = neg_q_q ? (~quo_q + 32'd1) : quo_q;
          r_d = neg_r_q ? (~rem_q + 32'd1) : rem_q;
        end
      end
      S_DONE: begin
        if (!valid) ready_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 5'd0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
      dvsr_q  <= 32'd0;
      dvnd_q  <= 32'd0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      div0_q  <= 1'b0;
      ready_q <= 1'b0;
      q_q     <= 32'd0;
      r_q     <= 32'd0;
    end else begin
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      dvnd_q  <= dvnd_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      div0_q  <= div0_d;
      ready_q <= ready_d;
      q_q     <= q_d;
      r_q     <= r_d;
    end
  end

  assign ready       = ready_q;
  assign q           = q_q;
  assign r           = r_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div32.sv
// Directed self-checking bench for div32: latency, signed/unsigned results,
// divide-by-zero, overflow, handshake hold/release, and reset mid-operation.
module tb_div32;

  logic        clk;
  logic        rst;
  logic [31:0] denom;
  logic [31:0] num;
  logic        signed_div;
  logic        valid;
  logic        ready;
  logic [31:0] q;
  logic [31:0] r;
  logic [1:0]  dbg_state_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] got_q, got_r;
  int          lat;

  div32 dut (
    .clk         (clk),
    .rst         (rst),
    .denom       (denom),
    .num         (num),
    .signed_div  (signed_div),
    .valid       (valid),
    .ready       (ready),
    .q           (q),
    .r           (r),
    .dbg_state_o (dbg_state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver: raise valid with operands, scramble operands after edge 0,
  // and count clocks (edge 0 is clock 1) until ready is visible.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] qo, output logic [31:0] ro, output int lt);
    @(negedge clk);
    denom = a; num = b; signed_div = s; valid = 1'b1;
    @(posedge clk); #1;
    lt = 1;
    denom = $urandom; num = $urandom; signed_div = 1'($urandom_range(0, 1));
    while (!ready && lt < 100) begin
      @(posedge clk); #1;
      lt++;
    end
    qo = q; ro = r;
  endtask

  task automatic drop_valid(input string tag);
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk); #1;
    check(tag, {31'd0, ready}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; denom = '0; num = '0; signed_div = 1'b0;
    #12;
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_q", q, 32'd0);
    check("reset_r", r, 32'd0);
    check("reset_state", {30'd0, dbg_state_o}, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op(32'd100, 32'd7, 1'b0, got_q, got_r, lat);
    check("u100_7_lat", lat, 32'd34);
    check("u100_7_q", got_q, 32'd14);
    check("u100_7_r", got_r, 32'd2);
    drop_valid("u100_7_clr");

    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, got_q, got_r, lat);
    check("sm7_2_lat", lat, 32'd34);
    check("sm7_2_q", got_q, 32'hFFFF_FFFD);
    check("sm7_2_r", got_r, 32'hFFFF_FFFF);
    drop_valid("sm7_2_clr");

    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, got_q, got_r, lat);
    check("s7_m2_q", got_q, 32'hFFFF_FFFD);
    check("s7_m2_r", got_r, 32'd1);
    drop_valid("s7_m2_clr");

    run_op(32'd5, 32'd0, 1'b1, got_q, got_r, lat);
    check("s_div0_lat", lat, 32'd34);
    check("s_div0_q", got_q, 32'hFFFF_FFFF);
    check("s_div0_r", got_r, 32'd5);
    drop_valid("s_div0_clr");

    run_op(32'd5, 32'd0, 1'b0, got_q, got_r, lat);
    check("u_div0_q", got_q, 32'hFFFF_FFFF);
    check("u_div0_r", got_r, 32'd5);
    drop_valid("u_div0_clr");

    run_op(32'hFFFF_FFFB, 32'd0, 1'b1, got_q, got_r, lat);
    check("s_neg_div0_q", got_q, 32'hFFFF_FFFF);
    check("s_neg_div0_r", got_r, 32'hFFFF_FFFB);
    drop_valid("s_neg_div0_clr");

    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, got_q, got_r, lat);
    check("s_ovf_q", got_q, 32'h8000_0000);
    check("s_ovf_r", got_r, 32'd0);
    drop_valid("s_ovf_clr");

    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, got_q, got_r, lat);
    check("u_ovf_q", got_q, 32'd0);
    check("u_ovf_r", got_r, 32'h8000_0000);
    drop_valid("u_ovf_clr");

    run_op(32'h8000_0000, 32'd2, 1'b1, got_q, got_r, lat);
    check("s_min_2_q", got_q, 32'hC000_0000);
    check("s_min_2_r", got_r, 32'd0);
    drop_valid("s_min_2_clr");

    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, got_q, got_r, lat);
    check("s_min_min_q", got_q, 32'd1);
    check("s_min_min_r", got_r, 32'd0);
    drop_valid("s_min_min_clr");

    run_op(32'hFFFF_FFFF, 32'h10, 1'b0, got_q, got_r, lat);
    check("u_big_q", got_q, 32'h0FFF_FFFF);
    check("u_big_r", got_r, 32'hF);
    drop_valid("u_big_clr");

    run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, got_q, got_r, lat);
    check("s_m100_m7_q", got_q, 32'd14);
    check("s_m100_m7_r", got_r, 32'hFFFF_FFFE);
    drop_valid("s_m100_m7_clr");

    // Handshake: hold valid for 5 clocks after ready, then release.
    run_op(32'd1000, 32'd33, 1'b0, got_q, got_r, lat);
    check("hs_q", got_q, 32'd30);
    check("hs_r", got_r, 32'd10);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hs_hold_ready", {31'd0, ready}, 32'd1);
      check("hs_hold_q", q, 32'd30);
      check("hs_hold_r", r, 32'd10);
    end
    drop_valid("hs_clr");
    check("hs_keep_q", q, 32'd30);
    check("hs_keep_r", r, 32'd10);
    check("hs_idle", {30'd0, dbg_state_o}, 32'd0);
    @(posedge clk); @(posedge clk);
    run_op(32'd12345, 32'd100, 1'b0, got_q, got_r, lat);
    check("b2b_lat", lat, 32'd34);
    check("b2b_q", got_q, 32'd123);
    check("b2b_r", got_r, 32'd45);
    drop_valid("b2b_clr");

    // valid dropped during CALC: the operation still completes, then clears.
    @(negedge clk);
    denom = 32'd1000; num = 32'd3; signed_div = 1'b0; valid = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    repeat (3) begin @(posedge clk); #1; lat++; end
    valid = 1'b0;
    while (!ready && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("drop_lat", lat, 32'd34);
    check("drop_q", q, 32'd333);
    check("drop_r", r, 32'd1);
    @(posedge clk); #1;
    check("drop_clr", {31'd0, ready}, 32'd0);

    // Reset at CALC iteration 10.
    @(negedge clk);
    denom = 32'd77; num = 32'd5; signed_div = 1'b0; valid = 1'b1;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_mid_ready", {31'd0, ready}, 32'd0);
    check("rst_mid_q", q, 32'd0);
    check("rst_mid_r", r, 32'd0);
    check("rst_mid_state", {30'd0, dbg_state_o}, 32'd0);
    valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    run_op(32'hFFFF_FFFF, 32'd3, 1'b0, got_q, got_r, lat);
    check("post_rst_lat", lat, 32'd34);
    check("post_rst_q", got_q, 32'h5555_5555);
    check("post_rst_r", got_r, 32'd0);
    drop_valid("post_rst_clr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div32.md
DIV32 -- requirements
Module: div32

Interface
REQ-001 The module SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 The module SHALL have ports: rst  input  1  reset; asynchronous, active-high.
REQ-003 The module SHALL have ports: denom  input  32  dividend (rs1 operand).
REQ-004 The module SHALL have ports: num  input  32  divisor (rs2 operand).
REQ-005 The module SHALL have ports: signed_div  input  1  1 = two's-complement signed divide, 0 = unsigned.
REQ-006 The module SHALL have ports: valid  input  1  request; held high by the requester until ready is seen, then dropped.
REQ-007 The module SHALL have ports: ready  output  1  result valid; registered.
REQ-008 The module SHALL have ports: q  output  32  quotient; registered.
REQ-009 The module SHALL have ports: r  output  32  remainder; registered.
REQ-010 The module SHALL have no parameters.

Function
REQ-011 The divider SHALL use states IDLE, CALC, FIX, DONE.
REQ-012 In IDLE with valid=1 at a clock edge (edge 0), the divider SHALL capture denom, num and signed_div, convert both operands to magnitudes when signed, record the result signs, clear the iteration counter, and go to CALC.
REQ-013 In CALC, the divider SHALL perform one restoring (shift-subtract) iteration per clock, producing one quotient bit MSB-first, for exactly 32 clocks (edges 1..32), then go to FIX.
REQ-014 In FIX (edge 33), the divider SHALL apply signs, load q and r, set ready=1, and go to DONE.
REQ-015 ready SHALL first be high after edge 33, giving a latency of 34 clocks from valid sampled to ready visible.
REQ-016 In DONE, ready, q and r SHALL hold while valid=1.
REQ-017 In DONE, when valid=0 is sampled, the divider SHALL clear ready on that edge and return to IDLE; q and r SHALL keep their values.
REQ-018 Operand inputs SHALL only be sampled at edge 0; changes during CALC, FIX or DONE SHALL be ignored.
REQ-019 If valid drops during CALC or FIX, the operation SHALL still complete; the divider SHALL enter DONE, then clear ready on the next edge.
REQ-020 A new request SHALL only be accepted in IDLE, so ready is never high at the start of a new operation.
REQ-021 Signed results SHALL truncate toward zero: quotient negative iff operand signs differ; remainder takes the dividend's sign; dividend = q*divisor + r.
REQ-022 Division by zero SHALL return q=0xFFFFFFFF and r=dividend in both signed and unsigned modes, with normal latency.
REQ-023 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL return q=0x80000000 and r=0.
REQ-024 Unsigned mode SHALL treat all 32 bits as magnitude.
REQ-025 Magnitudes of 0x80000000 SHALL be handled without overflow, using a 33-bit partial remainder.

Reset
REQ-026 rst=1 SHALL asynchronously force state=IDLE, ready=0, q=0, r=0, clear the counter, and abort any operation in progress.
REQ-027 After rst deasserts, the first valid=1 sampled in IDLE SHALL start a fresh operation.

Verification
REQ-028 Unsigned: denom=100, num=7, signed_div=0 -> ready exactly 34 clocks after valid sampled; q=14, r=2.
REQ-029 Signed: denom=0xFFFFFFF9 (-7), num=2, signed_div=1 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1); also 7/-2 -> q=-3, r=1.
REQ-030 Divide by zero: denom=5, num=0, in both modes -> q=0xFFFFFFFF, r=5.
REQ-031 Overflow: denom=0x80000000, num=0xFFFFFFFF, signed_div=1 -> q=0x80000000, r=0; same operands with signed_div=0 -> q=0, r=0x80000000.
REQ-032 Handshake: hold valid 5 clocks after ready, then drop -> ready stays high with q and r stable, clears one edge after valid=0 sampled; a back-to-back request 2 clocks later -> correct new result.
REQ-033 Reset mid-operation: rst pulse at CALC iteration 10 -> ready=0, q=r=0 immediately; next request 0xFFFFFFFF/3 unsigned -> q=0x55555555, r=0.
